// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO slice.
//   DEF_DATA_W / DEF_DEPTH : default payload width and entry count
//   cnt_width()            : width of an occupancy counter able to hold 0..depth
package fifo_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 16;

  // One extra bit over the address width so that "completely full" (== depth)
  // is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_param: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write payload
//   i_raddr : read address
//   o_rdata : read payload (combinational from i_raddr)
module fifo_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable read mode (registered or
// first-word-fall-through).
//   clk          : clock, all state updates on its rising edge
//   rstN         : asynchronous active-low reset
//   write_en     : write request        write_data : write payload
//   read_en      : read request         read_data  : read payload
//   clr_err      : synchronous clear of overflow/underflow
//   full, empty, almost_full, almost_empty : status decoded from the count
//   count        : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          write_en,
  input  logic [DATA_W-1:0]             write_data,
  input  logic                          read_en,
  output logic [DATA_W-1:0]             read_data,
  input  logic                          clr_err,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_ovf;
  logic              r_unf;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_bypass;
  logic              w_mem_we;
  logic              w_ovf_ev;
  logic              w_unf_ev;
  logic [DATA_W-1:0] w_mem_rdata;

  // Status is decoded only from the count register, so no input reaches a flag.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  assign w_wr_ok  = write_en && (!w_full  || read_en);
  assign w_rd_ok  = read_en  && (!w_empty || write_en);
  // Read and write on an empty FIFO: the word passes straight through and
  // never touches the array, so neither pointer moves.
  assign w_bypass = w_rd_ok && w_empty;
  assign w_mem_we = w_wr_ok && !w_bypass;

  assign w_ovf_ev = write_en && w_full  && !read_en;
  assign w_unf_ev = read_en  && w_empty && !write_en;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr),
    .i_wdata (write_data),
    .i_raddr (r_rptr),
    .o_rdata (w_mem_rdata)
  );

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_mem_we)              r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok && !w_bypass)  r_rptr <= r_rptr + 1'b1;
      if (w_wr_ok && !w_rd_ok)      r_count <= r_count + 1'b1;
      else if (w_rd_ok && !w_wr_ok) r_count <= r_count - 1'b1;
    end
  end

  // A new error in the same cycle as clr_err wins, so no event is lost.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_ev)     r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_unf_ev)     r_unf <= 1'b1;
      else if (clr_err) r_unf <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is visible before the pop; when empty the incoming word
      // is shown so a same-cycle read sees it.
      assign read_data = w_empty ? write_data : w_mem_rdata;
    end else begin : g_reg
      logic [DATA_W-1:0] r_rd_data;
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)        r_rd_data <= '0;
        else if (w_rd_ok) r_rd_data <= w_empty ? write_data : w_mem_rdata;
      end
      assign read_data = r_rd_data;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning entry count (power of two, >=2).
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full asserts when count >= AF_LEVEL.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, meaning almost_empty asserts when count <= AE_LEVEL.
REQ-005 The block SHALL have parameter FWFT, default 0, meaning 0 = registered read data, 1 = first-word-fall-through.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-007 clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 rstN  in  1  async active-low reset.
REQ-009 write_en  in  1  write request.
REQ-010 write_data  in  DATA_W  write payload.
REQ-011 read_en  in  1  read request.
REQ-012 read_data  out  DATA_W  read payload.
REQ-013 clr_err  in  1  synchronous clear of the sticky error flags.
REQ-014 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Accepted write (wr_ok) SHALL be write_en && (!full || read_en); accepted read (rd_ok) SHALL be read_en && (!empty || write_en).
REQ-018 Write when full with read_en SHALL be accepted, with read and write in the same cycle and count unchanged.
REQ-019 Read when empty with write_en SHALL bypass: read_data takes write_data per the FWFT timing, memory is not written, and count stays 0.
REQ-020 count SHALL be +1 on wr_ok only, -1 on rd_ok only, and unchanged when both or neither occur.
REQ-021 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); almost_full and almost_empty SHALL follow REQ-003/004; all flags SHALL be registered-state derived, with no combinational path from inputs.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
REQ-023 With FWFT=0, read_data SHALL update on the clock edge of rd_ok to the head entry (1-cycle latency) and SHALL hold its value otherwise.
REQ-024 With FWFT=1, read_data SHALL combinationally present the head entry while !empty, SHALL present write_data when empty (bypass case), and rd_ok SHALL pop the entry.
REQ-025 overflow SHALL set on write_en && full && !read_en; underflow SHALL set on read_en && empty && !write_en; the rejected operation SHALL have no effect on state.
REQ-026 clr_err SHALL clear both sticky flags, and a same-cycle new error SHALL take priority (the flag stays set).

Reset
REQ-027 On rstN low, pointers, count and read_data SHALL go to 0, empty and almost_empty to 1, and full, almost_full, overflow and underflow to 0, immediately.
REQ-028 Memory contents SHALL NOT be reset; reset assertion mid-operation SHALL discard all entries.
REQ-029 The first write SHALL be accepted on the first rising edge after rstN deasserts.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the default DATA_W/DEPTH constants and a function computing count width.
REQ-031 Storage SHALL be a sub-module fifo_mem (1 write port, 1 async read port, no reset); pointer/count/flag logic SHALL stay in sync_fifo_param.

Verification (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-032 Write 0x11..0x88 (8 writes) -> full=1 and count=8 after the 8th edge, almost_full from count 6; then 8 reads return 0x11..0x88 in order.
REQ-033 Full, then write 0x99 with read_en -> read returns 0x11, count stays 8, and 0x99 is read last.
REQ-034 Empty, then write_en=1, write_data=0x5A, read_en=1 -> read_data=0x5A (next cycle if FWFT=0, same cycle if FWFT=1), and count stays 0.
REQ-035 Write when full without read -> overflow=1 and sticky; clr_err=1 clears it; a subsequent read on empty -> underflow=1.
REQ-036 Fill 5 entries, 20 random interleaved ops, then assert rstN=0 mid-burst -> count=0, empty=1 asynchronously, and the next write/read returns the new data.
REQ-037 A 2M-cycle random test SHALL run against a queue scoreboard for FWFT=0 and FWFT=1 with no mismatch.
